// File: rtl/sqrt2_arbiter.sv
// Round-robin arbiter that time-shares one sqrt2 unit among NREQ requesters.
// Each grant runs CLEAR -> LOAD -> RUN -> RESP, with a watchdog on the RUN phase.
module sqrt2_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [16*NREQ-1:0] REQ_DATA,
  output logic [NREQ-1:0]   REQ_READY,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [IDW-1:0]    RSP_ID,
  output logic [15:0]       RSP_DATA,
  output logic [3:0]        RSP_FLAGS,
  output logic              BUSY,
  output logic              SQ_ENABLE,
  inout  wire  [15:0]       SQ_IO_DATA,
  input  logic              SQ_RESULT,
  input  logic              SQ_IS_NAN,
  input  logic              SQ_IS_PINF,
  input  logic              SQ_IS_NINF
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  op_id;
  logic [15:0]     operand;
  logic [CW-1:0]   run_cnt;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  next_ptr;
  logic [15:0]     gnt_data;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!gnt_found && REQ_VALID[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IDW'(k)) gnt_data = REQ_DATA[16*k +: 16];
    end
  end

  assign next_ptr = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);

  // The strobe is suppressed while reset is held so nothing looks accepted.
  always_comb begin
    REQ_READY = '0;
    if (state == IDLE && RESET_N && gnt_found) REQ_READY[gnt_idx] = 1'b1;
  end

  assign SQ_IO_DATA = (state == LOAD && RESET_N) ? operand : 'z;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      ptr       <= '0;
      op_id     <= '0;
      run_cnt   <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= '0;
      RSP_DATA  <= '0;
      RSP_FLAGS <= '0;
      SQ_ENABLE <= 1'b0;
      BUSY      <= 1'b0;
      // NOTE: operand is pure datapath, only consumed after a fresh grant
      // loads it, so it is deliberately left out of the reset.
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            operand   <= gnt_data;
            op_id     <= gnt_idx;
            ptr       <= next_ptr;
            BUSY      <= 1'b1;
            SQ_ENABLE <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          SQ_ENABLE <= 1'b1;
          state     <= LOAD;
        end
        LOAD: begin
          run_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          if (SQ_RESULT) begin
            RSP_DATA  <= SQ_IO_DATA;
            RSP_FLAGS <= {1'b0, SQ_IS_NINF, SQ_IS_PINF, SQ_IS_NAN};
            RSP_ID    <= op_id;
            RSP_VALID <= 1'b1;
            SQ_ENABLE <= 1'b0;
            state     <= RESP;
          end else if (run_cnt == CW'(TIMEOUT - 1)) begin
            // Watchdog expiry answers with a quiet NaN tagged as a timeout.
            RSP_DATA  <= 16'h7E00;
            RSP_FLAGS <= 4'b1001;
            RSP_ID    <= op_id;
            RSP_VALID <= 1'b1;
            SQ_ENABLE <= 1'b0;
            state     <= RESP;
          end else begin
            run_cnt <= run_cnt + CW'(1);
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt2_arbiter.sv
// Directed bench for sqrt2_arbiter with a behavioural sqrt2 unit on the shared bus.
// The undriven bus floats high through a pull, so "released" reads as 16'hFFFF.
module tb_sqrt2_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 32;
  localparam int IDW     = 2;
  localparam int LAT     = 3;

  logic             CLK;
  logic             RESET_N;
  logic [NREQ-1:0]  REQ_VALID;
  logic [16*NREQ-1:0] REQ_DATA;
  logic [NREQ-1:0]  REQ_READY;
  logic             RSP_VALID;
  logic             RSP_READY;
  logic [IDW-1:0]   RSP_ID;
  logic [15:0]      RSP_DATA;
  logic [3:0]       RSP_FLAGS;
  logic             BUSY;
  logic             SQ_ENABLE;
  tri1  [15:0]      sq_io;
  logic             SQ_RESULT;
  logic             SQ_IS_NAN;
  logic             SQ_IS_PINF;
  logic             SQ_IS_NINF;

  int n_vec = 0;
  int n_err = 0;

  sqrt2_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .REQ_VALID  (REQ_VALID),
    .REQ_DATA   (REQ_DATA),
    .REQ_READY  (REQ_READY),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_ID     (RSP_ID),
    .RSP_DATA   (RSP_DATA),
    .RSP_FLAGS  (RSP_FLAGS),
    .BUSY       (BUSY),
    .SQ_ENABLE  (SQ_ENABLE),
    .SQ_IO_DATA (sq_io),
    .SQ_RESULT  (SQ_RESULT),
    .SQ_IS_NAN  (SQ_IS_NAN),
    .SQ_IS_PINF (SQ_IS_PINF),
    .SQ_IS_NINF (SQ_IS_NINF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Truncating sqrt2 table: {ninf, pinf, nan, result}
  function automatic logic [18:0] sqrt_lut(input logic [15:0] op);
    case (op)
      16'h4000: return {3'b000, 16'h3DA8};
      16'h3C00: return {3'b000, 16'h3C00};
      16'h4200: return {3'b000, 16'h3EED};
      16'h4500: return {3'b000, 16'h4078};
      16'h4700: return {3'b000, 16'h414A};
      16'hC000: return {3'b001, 16'hFE00};
      16'h7C00: return {3'b010, 16'h7C00};
      default:  return '0;
    endcase
  endfunction

  // Behavioural unit: held in reset while disabled, takes the operand on the
  // first enabled edge, answers LAT cycles into RUN.
  logic        m_loaded = 1'b0;
  int          m_cnt    = 0;
  logic [15:0] m_op     = '0;
  logic        stuck    = 1'b0;
  logic [18:0] m_res;
  logic        m_fire;

  always @(posedge CLK) begin
    if (!SQ_ENABLE) begin
      m_loaded <= 1'b0;
      m_cnt    <= 0;
    end else if (!m_loaded) begin
      m_loaded <= 1'b1;
      m_op     <= sq_io;
      m_cnt    <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign m_res      = sqrt_lut(m_op);
  assign m_fire     = SQ_ENABLE && m_loaded && (m_cnt >= LAT) && !stuck;
  assign sq_io      = m_fire ? m_res[15:0] : 'z;
  assign SQ_RESULT  = m_fire;
  assign SQ_IS_NAN  = m_fire & m_res[16];
  assign SQ_IS_PINF = m_fire & m_res[17];
  assign SQ_IS_NINF = m_fire & m_res[18];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] v);
    REQ_DATA[16*i +: 16] = v;
  endtask

  // Called at a negedge in IDLE with REQ_VALID already applied; returns at
  // the negedge of the IDLE cycle that follows the response handshake.
  task automatic txn(input string tag, input logic [3:0] exp_gnt, input logic [15:0] exp_op,
                     input logic [15:0] exp_data, input logic [3:0] exp_flags,
                     input int exp_lat, input int hold, input bit drop);
    int          k;
    logic [3:0]  leak;
    logic [1:0]  eid;
    logic [22:0] exp_rsp;
    eid = '0;
    for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) eid = 2'(i);
    exp_rsp = {1'b1, eid, exp_flags, exp_data};
    #1 check({tag, " grant"}, REQ_READY, exp_gnt);
    leak = '0;
    k    = 0;
    while (k < 200) begin
      @(negedge CLK);
      k++;
      if (drop) REQ_VALID = '0;
      if (k == 1) check({tag, " clear"}, {BUSY, SQ_ENABLE, sq_io}, {2'b10, 16'hFFFF});
      if (k == 2) check({tag, " load"}, {BUSY, SQ_ENABLE, sq_io}, {2'b11, exp_op});
      leak |= REQ_READY;
      if (RSP_VALID) break;
    end
    check({tag, " latency"}, k, exp_lat);
    check({tag, " rsp"}, {RSP_VALID, RSP_ID, RSP_FLAGS, RSP_DATA}, exp_rsp);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      leak |= REQ_READY;
      check({tag, " hold"}, {RSP_VALID, RSP_ID, RSP_FLAGS, RSP_DATA}, exp_rsp);
    end
    check({tag, " ready_busy"}, leak, 4'b0000);
    RSP_READY = 1'b1;
    @(negedge CLK);
    RSP_READY = 1'b0;
    check({tag, " release"}, {RSP_VALID, BUSY}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic idle_bad;
    RESET_N   = 1'b0;
    REQ_VALID = '0;
    REQ_DATA  = '0;
    RSP_READY = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset state; a pending request must not be acknowledged under reset.
    REQ_VALID = 4'b1111;
    #1 check("rst ready", REQ_READY, 4'b0000);
    check("rst outs", {RSP_VALID, BUSY, SQ_ENABLE, RSP_ID, RSP_FLAGS, RSP_DATA}, '0);
    check("rst bus", sq_io, 16'hFFFF);
    @(negedge CLK);
    RESET_N   = 1'b1;
    REQ_VALID = '0;

    // Single request, valid dropped after acceptance.
    set_op(0, 16'h4000);
    REQ_VALID = 4'b0001;
    txn("single", 4'b0001, 16'h4000, 16'h3DA8, 4'b0000, 7, 0, 1'b1);

    // Reset pulse so the all-four sweep starts from requester 0.
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    set_op(0, 16'h3C00);
    set_op(1, 16'h4200);
    set_op(2, 16'h4500);
    set_op(3, 16'h4700);
    REQ_VALID = 4'b1111;
    txn("all0", 4'b0001, 16'h3C00, 16'h3C00, 4'b0000, 7, 0, 1'b0);
    txn("all1", 4'b0010, 16'h4200, 16'h3EED, 4'b0000, 7, 0, 1'b0);
    txn("all2", 4'b0100, 16'h4500, 16'h4078, 4'b0000, 7, 0, 1'b0);
    txn("all3", 4'b1000, 16'h4700, 16'h414A, 4'b0000, 7, 0, 1'b0);

    // Two contenders alternate.
    REQ_VALID = 4'b0101;
    txn("rr0", 4'b0001, 16'h3C00, 16'h3C00, 4'b0000, 7, 0, 1'b0);
    txn("rr2", 4'b0100, 16'h4500, 16'h4078, 4'b0000, 7, 0, 1'b0);
    txn("rr0b", 4'b0001, 16'h3C00, 16'h3C00, 4'b0000, 7, 0, 1'b0);
    txn("rr2b", 4'b0100, 16'h4500, 16'h4078, 4'b0000, 7, 0, 1'b0);

    // Special operands: flags are {timeout, ninf, pinf, nan}.
    set_op(1, 16'hC000);
    REQ_VALID = 4'b0010;
    txn("neg", 4'b0010, 16'hC000, 16'hFE00, 4'b0001, 7, 0, 1'b0);
    set_op(3, 16'h7C00);
    REQ_VALID = 4'b1000;
    txn("pinf", 4'b1000, 16'h7C00, 16'h7C00, 4'b0010, 7, 0, 1'b0);

    // Unit never answers: response lands TIMEOUT cycles after RUN entry.
    stuck = 1'b1;
    set_op(2, 16'h4200);
    REQ_VALID = 4'b0100;
    txn("timeout", 4'b0100, 16'h4200, 16'h7E00, 4'b1001, 3 + TIMEOUT, 0, 1'b1);
    stuck = 1'b0;

    // Back-pressured response stays stable.
    set_op(1, 16'h4000);
    REQ_VALID = 4'b0010;
    txn("hold", 4'b0010, 16'h4000, 16'h3DA8, 4'b0000, 7, 5, 1'b1);

    // Reset in the middle of RUN discards the operation.
    set_op(2, 16'h4700);
    REQ_VALID = 4'b0100;
    #1 check("abort grant", REQ_READY, 4'b0100);
    repeat (4) @(negedge CLK);
    check("abort run", {BUSY, SQ_ENABLE}, 2'b11);
    RESET_N   = 1'b0;
    REQ_VALID = '0;
    @(negedge CLK);
    check("abort outs", {RSP_VALID, BUSY, SQ_ENABLE, RSP_ID, RSP_FLAGS, RSP_DATA}, '0);
    check("abort bus", {REQ_READY, sq_io}, {4'b0000, 16'hFFFF});
    RESET_N  = 1'b1;
    idle_bad = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      idle_bad |= RSP_VALID | BUSY | SQ_ENABLE;
    end
    check("abort no_rsp", idle_bad, 1'b0);

    // Pointer restarts at 0, so requester 0 wins over requester 3.
    set_op(0, 16'h4500);
    set_op(3, 16'h4700);
    REQ_VALID = 4'b1001;
    txn("post", 4'b0001, 16'h4500, 16'h4078, 4'b0000, 7, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
